// File: rtl/interp_mux_sequencer.sv
// interp_mux_sequencer: steps input_array_mux.sel through the enabled
// line groups (int, a, b, c) and offers each settled line downstream.
//
// Ports:
//   clock, reset        rising-edge clock, async active-high reset
//   start, cfg_mask     run request and group-enable mask ([0]int..[3]c)
//   sel                 mux select code
//   out_valid/ready     line handshake toward the FIR stage
//   out_kind, out_last  group of the current line, final line of the run
//   busy, done          run in progress, one-cycle end-of-run pulse
//   stall_cnt           (ISEQ_STALL_CNT_EN only) saturating back-pressure count
//
// Optional feature macro: ISEQ_STALL_CNT_EN
module interp_mux_sequencer #(
   parameter int N_INT   = 15,
   parameter int N_HALF  = 8,
   parameter int MUX_LAT = 1,
   parameter int SEL_W   = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       cfg_mask,
   output logic [SEL_W-1:0] sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_kind,
   output logic             out_last,
   output logic             busy,
   output logic             done
`ifdef ISEQ_STALL_CNT_EN
   ,
   output logic [15:0]      stall_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, SETTLE, OFFER, DONE} state_t;

   localparam logic [2:0] LAT_M1 = 3'(MUX_LAT - 1);
   localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);
   localparam logic [SEL_W-1:0] BASE_A = SEL_W'(N_INT);
   localparam logic [SEL_W-1:0] BASE_B = SEL_W'(N_INT + N_HALF);
   localparam logic [SEL_W-1:0] BASE_C = SEL_W'(N_INT + 2 * N_HALF);
   localparam logic [SEL_W-1:0] END_I  = SEL_W'(N_INT - 1);
   localparam logic [SEL_W-1:0] END_A  = SEL_W'(N_INT + N_HALF - 1);
   localparam logic [SEL_W-1:0] END_B  = SEL_W'(N_INT + 2 * N_HALF - 1);
   localparam logic [SEL_W-1:0] END_C  = SEL_W'(N_INT + 3 * N_HALF - 1);

   function automatic logic [SEL_W-1:0] grp_base(input logic [1:0] g);
      case (g)
         2'd0:    grp_base = '0;
         2'd1:    grp_base = BASE_A;
         2'd2:    grp_base = BASE_B;
         default: grp_base = BASE_C;
      endcase
   endfunction

   function automatic logic [SEL_W-1:0] grp_end(input logic [1:0] g);
      case (g)
         2'd0:    grp_end = END_I;
         2'd1:    grp_end = END_A;
         2'd2:    grp_end = END_B;
         default: grp_end = END_C;
      endcase
   endfunction

   state_t           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [3:0]       mask_q, mask_d;

   logic [1:0] kind;
   logic [1:0] nxt_g;
   logic       nxt_found;
   logic [1:0] first_g;
   logic       at_end;
   logic       active;

   // group of the current line follows directly from the sel range
   always_comb begin
      kind = 2'd0;
      unique case (1'b1)
         (sel_q < BASE_A):                     kind = 2'd0;
         (sel_q >= BASE_A && sel_q < BASE_B): kind = 2'd1;
         (sel_q >= BASE_B && sel_q < BASE_C): kind = 2'd2;
         (sel_q >= BASE_C):                   kind = 2'd3;
      endcase
   end

   // lowest enabled group above the current one
   always_comb begin
      nxt_found = 1'b0;
      nxt_g     = kind;
      for (int i = 3; i >= 0; i--) begin
         if (mask_q[i] && i > int'(kind)) begin
            nxt_g     = 2'(i);
            nxt_found = 1'b1;
         end
      end
   end

   always_comb begin
      first_g = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (cfg_mask[i]) first_g = 2'(i);
      end
   end

   assign at_end = (sel_q == grp_end(kind));
   assign active = (state_q == SETTLE) || (state_q == OFFER);

   assign sel       = sel_q;
   assign out_valid = (state_q == OFFER);
   assign out_kind  = kind;
   assign out_last  = active && at_end && !nxt_found;
   assign busy      = active;
   assign done      = (state_q == DONE);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               mask_d = cfg_mask;
               if (cfg_mask == 4'd0) begin
                  state_d = DONE;
               end else begin
                  sel_d   = grp_base(first_g);
                  cnt_d   = LAT_M1;
                  state_d = SETTLE;
               end
            end
         end
         SETTLE: begin
            if (cnt_q == 3'd0) state_d = OFFER;
            else cnt_d = cnt_q - 3'd1;
         end
         OFFER: begin
            if (out_ready) begin
               if (out_last) begin
                  state_d = DONE;
               end else begin
                  sel_d   = at_end ? grp_base(nxt_g)
                                   : sel_q + SEL_ONE;
                  cnt_d   = LAT_M1;
                  state_d = SETTLE;
               end
            end
         end
         DONE: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= '0;
         cnt_q   <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
      end
   end

`ifdef ISEQ_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (state_q == IDLE && start)
         stall_d = '0;
      else if (out_valid && !out_ready && stall_q != 16'hFFFF)
         stall_d = stall_q + 16'd1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) stall_q <= '0;
      else       stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_interp_mux_sequencer.sv
// tb_interp_mux_sequencer: randomized self-checking bench for
// interp_mux_sequencer, with a queue-based model of the line order.
module tb_interp_mux_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       ready = 1'b1;
   logic [3:0] mask = 4'd0;
   logic       which = 1'b0;

   logic [7:0] sel1, sel3;
   logic       v1, v3, l1, l3, b1, b3, d1, d3;
   logic [1:0] k1, k3;
`ifdef ISEQ_STALL_CNT_EN
   logic [15:0] st1, st3;
`endif

   logic [7:0] o_sel;
   logic       o_valid, o_last, o_busy, o_done;
   logic [1:0] o_kind;
   assign o_sel   = which ? sel3 : sel1;
   assign o_valid = which ? v3 : v1;
   assign o_last  = which ? l3 : l1;
   assign o_busy  = which ? b3 : b1;
   assign o_done  = which ? d3 : d1;
   assign o_kind  = which ? k3 : k1;

   interp_mux_sequencer dut (
      .clock(clk), .reset(rst), .start(start), .cfg_mask(mask),
      .sel(sel1), .out_valid(v1), .out_ready(ready), .out_kind(k1),
      .out_last(l1), .busy(b1), .done(d1)
`ifdef ISEQ_STALL_CNT_EN
      , .stall_cnt(st1)
`endif
   );

   interp_mux_sequencer #(.MUX_LAT(3)) dut3 (
      .clock(clk), .reset(rst), .start(start), .cfg_mask(mask),
      .sel(sel3), .out_valid(v3), .out_ready(ready), .out_kind(k3),
      .out_last(l3), .busy(b3), .done(d3)
`ifdef ISEQ_STALL_CNT_EN
      , .stall_cnt(st3)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int hs_sel[$];
   int hs_kind[$];
   bit hs_last[$];
   int exp_sel[$];
   int exp_kind[$];
   int n_done, done_c, busy_cyc, valid_cyc, first_valid_c;
   int stall_obs, held_cyc, lat_bad, stopped;

   // expected line order: each enabled group in turn, all its lines
   function automatic void build_exp(input logic [3:0] m);
      exp_sel.delete();
      exp_kind.delete();
      for (int g = 0; g < 4; g++) begin
         if (m[g]) begin
            int len;
            int base;
            len  = (g == 0) ? 15 : 8;
            base = (g == 0) ? 0 : 15 + (g - 1) * 8;
            for (int j = 0; j < len; j++) begin
               exp_sel.push_back(base + j);
               exp_kind.push_back(g);
            end
         end
      end
   endfunction

   // rmode: 0 ready high, 1 random ready, 2 five-cycle stall at sel 3
   task automatic collect(input logic [3:0] m, input int rmode,
                          input int max_cyc, input int stop_sel,
                          input int xs_at);
      int c, post, hold, last_change, lat;
      logic [7:0] prev_sel;
      logic prev_v;
      hs_sel.delete();
      hs_kind.delete();
      hs_last.delete();
      n_done = 0; done_c = -1; busy_cyc = 0; valid_cyc = 0;
      first_valid_c = -1; stall_obs = 0; held_cyc = 0;
      lat_bad = 0; stopped = 0;
      lat = which ? 3 : 1;
      @(negedge clk);
      start = 1'b1;
      mask  = m;
      ready = 1'b1;
      prev_sel = o_sel;
      prev_v = 1'b0;
      last_change = 1;
      c = 0; post = -1; hold = 0;
      while (c < max_cyc) begin
         @(negedge clk);
         c++;
         start = (c == xs_at);
         mask  = 4'($urandom);
         case (rmode)
            1: ready = ($urandom_range(99) < 70);
            2: begin
               if (o_valid && o_sel == 8'd3 && hold < 5) begin
                  ready = 1'b0;
                  hold++;
               end else begin
                  ready = 1'b1;
               end
            end
            default: ready = 1'b1;
         endcase
         if (o_sel != prev_sel) last_change = c;
         prev_sel = o_sel;
         if (o_valid) valid_cyc++;
         if (o_valid && !prev_v) begin
            if (first_valid_c < 0) first_valid_c = c - 1;
            if (c - last_change != lat) lat_bad++;
         end
         prev_v = o_valid;
         if (o_valid && !ready) stall_obs++;
         if (o_valid && o_sel == 8'd3 && o_kind == 2'd0) held_cyc++;
         if (o_busy) busy_cyc++;
         if (o_done) begin
            n_done++;
            done_c = c - 1;
            if (post < 0) post = 6;
         end
         if (stop_sel >= 0 && o_valid && int'(o_sel) == stop_sel) begin
            ready = 1'b0;
            stopped = 1;
            break;
         end
         if (o_valid && ready) begin
            hs_sel.push_back(int'(o_sel));
            hs_kind.push_back(int'(o_kind));
            hs_last.push_back(o_last);
         end
         if (post > 0) begin
            post--;
            if (post == 0) break;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({sel1, v1, k1, l1, b1, d1} !== 14'd0) begin
         errors++;
         $display("FAIL reset_outputs got sel=%0d v=%0d k=%0d l=%0d b=%0d d=%0d want all 0",
                  sel1, v1, k1, l1, b1, d1);
      end
`ifdef ISEQ_STALL_CNT_EN
      checks++;
      if (st1 !== 16'd0) begin
         errors++;
         $display("FAIL reset_stall got %0d want 0", st1);
      end
`endif
      rst = 1'b0;
   endtask

   task automatic test_full_run();
      build_exp(4'hF);
      collect(4'hF, 0, 200, -1, 79);
      checks++;
      if (hs_sel.size() != exp_sel.size()) begin
         errors++;
         $display("FAIL full_count got %0d want %0d", hs_sel.size(), exp_sel.size());
      end
      for (int i = 0; i < hs_sel.size() && i < exp_sel.size(); i++) begin
         checks++;
         if (hs_sel[i] !== exp_sel[i] || hs_kind[i] !== exp_kind[i] ||
             hs_last[i] !== (i == exp_sel.size() - 1)) begin
            errors++;
            $display("FAIL full_line%0d got sel=%0d k=%0d l=%0d want sel=%0d k=%0d",
                     i, hs_sel[i], hs_kind[i], hs_last[i], exp_sel[i], exp_kind[i]);
         end
      end
      checks++;
      if (n_done != 1 || done_c != 78 || busy_cyc != 78 || first_valid_c != 1) begin
         errors++;
         $display("FAIL full_timing got done=%0d at %0d busy=%0d fv=%0d want 1 78 78 1",
                  n_done, done_c, busy_cyc, first_valid_c);
      end
   endtask

   task automatic test_sparse_mask();
      build_exp(4'b1010);
      collect(4'b1010, 0, 200, -1, -1);
      checks++;
      if (hs_sel.size() != 16 || n_done != 1) begin
         errors++;
         $display("FAIL sparse_count got %0d done=%0d want 16 1", hs_sel.size(), n_done);
      end
      for (int i = 0; i < hs_sel.size() && i < exp_sel.size(); i++) begin
         checks++;
         if (hs_sel[i] !== exp_sel[i] || hs_kind[i] !== exp_kind[i] ||
             hs_last[i] !== (i == exp_sel.size() - 1)) begin
            errors++;
            $display("FAIL sparse_line%0d got sel=%0d k=%0d l=%0d want sel=%0d k=%0d",
                     i, hs_sel[i], hs_kind[i], hs_last[i], exp_sel[i], exp_kind[i]);
         end
      end
   endtask

   task automatic test_zero_mask();
      collect(4'h0, 1, 40, -1, -1);
      checks++;
      if (n_done != 1 || done_c != 0 || busy_cyc != 0 ||
          valid_cyc != 0 || hs_sel.size() != 0) begin
         errors++;
         $display("FAIL zero_mask got done=%0d at %0d busy=%0d valid=%0d hs=%0d want 1 0 0 0 0",
                  n_done, done_c, busy_cyc, valid_cyc, hs_sel.size());
      end
   endtask

   task automatic test_backpressure();
      build_exp(4'hF);
      collect(4'hF, 2, 200, -1, -1);
      checks++;
      if (held_cyc != 6 || done_c != 83 || n_done != 1) begin
         errors++;
         $display("FAIL stall_hold got held=%0d done_at=%0d n=%0d want 6 83 1",
                  held_cyc, done_c, n_done);
      end
      checks++;
      if (hs_sel.size() != 39 || hs_sel[3] !== 3 || hs_sel[4] !== 4) begin
         errors++;
         $display("FAIL stall_lines got %0d lines want 39 in order", hs_sel.size());
      end
`ifdef ISEQ_STALL_CNT_EN
      checks++;
      if (st1 !== 16'd5) begin
         errors++;
         $display("FAIL stall_cnt got %0d want 5", st1);
      end
`endif
   endtask

   task automatic test_random();
      logic [3:0] m;
      for (int r = 0; r < 6; r++) begin
         m = 4'($urandom_range(15, 1));
         build_exp(m);
         collect(m, 1, 600, -1, -1);
         checks++;
         if (hs_sel.size() != exp_sel.size() || n_done != 1 || lat_bad != 0) begin
            errors++;
            $display("FAIL rand%0d mask=%h got hs=%0d done=%0d latbad=%0d want %0d 1 0",
                     r, m, hs_sel.size(), n_done, lat_bad, exp_sel.size());
         end
         for (int i = 0; i < hs_sel.size() && i < exp_sel.size(); i++) begin
            checks++;
            if (hs_sel[i] !== exp_sel[i] || hs_kind[i] !== exp_kind[i] ||
                hs_last[i] !== (i == exp_sel.size() - 1)) begin
               errors++;
               $display("FAIL rand%0d_line%0d got sel=%0d k=%0d l=%0d want sel=%0d k=%0d",
                        r, i, hs_sel[i], hs_kind[i], hs_last[i], exp_sel[i], exp_kind[i]);
            end
         end
`ifdef ISEQ_STALL_CNT_EN
         checks++;
         if (int'(st1) != stall_obs) begin
            errors++;
            $display("FAIL rand%0d_stall got %0d want %0d", r, st1, stall_obs);
         end
`endif
      end
   endtask

   task automatic test_reset_mid_run();
      int late_done;
      collect(4'hF, 0, 200, 20, -1);
      checks++;
      if (stopped != 1) begin
         errors++;
         $display("FAIL abort_reach got %0d want 1 (sel 20 offered)", stopped);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({sel1, v1, k1, l1, b1, d1} !== 14'd0) begin
         errors++;
         $display("FAIL abort_outputs got sel=%0d v=%0d k=%0d l=%0d b=%0d d=%0d want all 0",
                  sel1, v1, k1, l1, b1, d1);
      end
      @(negedge clk);
      rst = 1'b0;
      late_done = 0;
      repeat (4) begin
         @(negedge clk);
         if (d1) late_done++;
      end
      checks++;
      if (late_done != 0) begin
         errors++;
         $display("FAIL abort_done got %0d pulses want 0", late_done);
      end
      build_exp(4'h1);
      collect(4'h1, 0, 100, -1, -1);
      checks++;
      if (hs_sel.size() != 15 || n_done != 1) begin
         errors++;
         $display("FAIL after_abort got hs=%0d done=%0d want 15 1", hs_sel.size(), n_done);
      end
      for (int i = 0; i < hs_sel.size() && i < exp_sel.size(); i++) begin
         checks++;
         if (hs_sel[i] !== exp_sel[i] || hs_kind[i] !== 0 ||
             hs_last[i] !== (i == 14)) begin
            errors++;
            $display("FAIL after_abort_line%0d got sel=%0d k=%0d l=%0d want sel=%0d k=0",
                     i, hs_sel[i], hs_kind[i], hs_last[i], exp_sel[i]);
         end
      end
   endtask

   task automatic test_lat3_back_to_back();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      which = 1'b1;
      build_exp(4'hF);
      collect(4'hF, 0, 400, -1, 10);
      checks++;
      if (hs_sel.size() != 39 || n_done != 1 || lat_bad != 0 ||
          first_valid_c != 3 || done_c != 156) begin
         errors++;
         $display("FAIL lat3 got hs=%0d done=%0d latbad=%0d fv=%0d at=%0d want 39 1 0 3 156",
                  hs_sel.size(), n_done, lat_bad, first_valid_c, done_c);
      end
      for (int i = 0; i < hs_sel.size() && i < exp_sel.size(); i++) begin
         checks++;
         if (hs_sel[i] !== exp_sel[i] || hs_kind[i] !== exp_kind[i] ||
             hs_last[i] !== (i == exp_sel.size() - 1)) begin
            errors++;
            $display("FAIL lat3_line%0d got sel=%0d k=%0d l=%0d want sel=%0d k=%0d",
                     i, hs_sel[i], hs_kind[i], hs_last[i], exp_sel[i], exp_kind[i]);
         end
      end
      which = 1'b0;
   endtask

   initial begin
      test_reset();
      test_full_run();
      test_sparse_mask();
      test_zero_mask();
      test_backpressure();
      test_random();
      test_reset_mid_run();
      test_lat3_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

endmodule
